// File: rtl/eff_crop_win.sv
// eff_crop_win: crops the heff/veff-qualified pixel stream to a programmable
// rectangle, tags the last pixel of each window row (eop_out) and of the whole
// window (eol_out), and measures the input frame geometry.
module eff_crop_win #(
   parameter int dat_w = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             soft_rst,
   input  logic             op_start,
   input  logic [15:0]      crop_x0,
   input  logic [15:0]      crop_y0,
   input  logic [15:0]      crop_w,
   input  logic [15:0]      crop_h,
   output logic             req_out,
   input  logic             rdy_in,
   input  logic             heff_in,
   input  logic             veff_in,
   input  logic [dat_w-1:0] din,
   output logic             rdy_out,
   input  logic             req_in,
   output logic [dat_w-1:0] dout,
   output logic             eop_out,
   output logic             eol_out,
   output logic [15:0]      frm_w,
   output logic [15:0]      frm_h,
   output logic             frm_done,
   output logic             err_trunc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic        full;
   logic        out_val;
   logic        acc;
   logic        run_acc;
   logic        win_acc;

   logic        heff_d;
   logic        veff_d;
   logic        hfall;
   logic        vfall;

   logic [15:0] x_cnt;
   logic [15:0] y_cnt;
   logic        x_nz;
   logic        y_inc;
   logic [15:0] y_meas;

   logic [15:0] x0_s;
   logic [15:0] y0_s;
   logic [15:0] w_s;
   logic [15:0] h_s;

   logic [16:0] x_end;
   logic [16:0] y_end;
   logic        in_win;
   logic        x_last;
   logic        y_last;
   logic        trunc;

   // Handshake and edge qualifiers
   assign rdy_out = full;
   assign out_val = req_in & full;
   assign acc     = req_out & rdy_in & heff_in & veff_in;
   assign hfall   = heff_d & ~heff_in;
   assign vfall   = veff_d & ~veff_in;

   // Counting is frozen outside RUN and in the cycle op_start re-arms the block
   assign run_acc = acc & (state == RUN) & ~op_start;
   assign win_acc = run_acc & in_win;

   // Window bounds in 17 bits so origin+size never wraps
   assign x_end  = {1'b0, x0_s} + {1'b0, w_s};
   assign y_end  = {1'b0, y0_s} + {1'b0, h_s};
   assign in_win = ({1'b0, x_cnt} >= {1'b0, x0_s}) & ({1'b0, x_cnt} < x_end) &
                   ({1'b0, y_cnt} >= {1'b0, y0_s}) & ({1'b0, y_cnt} < y_end);
   assign x_last = ({1'b0, x_cnt} == (x_end - 17'd1));
   assign y_last = ({1'b0, y_cnt} == (y_end - 17'd1));

   // Line count including a line whose hfall coincides with vfall
   assign x_nz   = (x_cnt != '0);
   assign y_inc  = hfall & x_nz;
   assign y_meas = (y_inc && (y_cnt != '1)) ? (y_cnt + 16'd1) : y_cnt;
   assign trunc  = (h_s != '0) & ({1'b0, y_meas} < y_end);

   // Next-state and upstream request
   always_comb begin
      state_nx = state;
      req_out  = 1'b0;
      if (soft_rst) begin
         state_nx = IDLE;
      end else if (op_start) begin
         state_nx = SYNC;
      end else if ((state == SYNC) && !veff_in) begin
         state_nx = RUN;
      end
      if (!soft_rst) begin
         case (state)
            SYNC:    req_out = 1'b1;
            RUN:     req_out = ~full | out_val;
            default: req_out = 1'b0;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Registered copies of the effective flags for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         heff_d <= 1'b0;
         veff_d <= 1'b0;
      end else if (soft_rst) begin
         heff_d <= 1'b0;
         veff_d <= 1'b0;
      end else begin
         heff_d <= heff_in;
         veff_d <= veff_in;
      end
   end

   // Shadow window: reloaded on arm and at each frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_s <= '0;
         y0_s <= '0;
         w_s  <= '0;
         h_s  <= '0;
      end else if (soft_rst) begin
         x0_s <= '0;
         y0_s <= '0;
         w_s  <= '0;
         h_s  <= '0;
      end else if (op_start || vfall) begin
         x0_s <= crop_x0;
         y0_s <= crop_y0;
         w_s  <= crop_w;
         h_s  <= crop_h;
      end
   end

   // Saturating pixel and line position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (soft_rst || op_start) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (state == RUN) begin
         if (hfall) begin
            x_cnt <= '0;
         end else if (acc && (x_cnt != '1)) begin
            x_cnt <= x_cnt + 16'd1;
         end
         if (vfall) begin
            y_cnt <= '0;
         end else if (y_inc && (y_cnt != '1)) begin
            y_cnt <= y_cnt + 16'd1;
         end
      end
   end

   // Frame geometry measurement and end-of-frame pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_w     <= '0;
         frm_h     <= '0;
         frm_done  <= 1'b0;
         err_trunc <= 1'b0;
      end else if (soft_rst) begin
         frm_w     <= '0;
         frm_h     <= '0;
         frm_done  <= 1'b0;
         err_trunc <= 1'b0;
      end else begin
         frm_done  <= 1'b0;
         err_trunc <= 1'b0;
         if ((state == RUN) && !op_start) begin
            if (hfall && x_nz) begin
               frm_w <= x_cnt;
            end
            if (vfall) begin
               frm_h     <= y_meas;
               frm_done  <= 1'b1;
               err_trunc <= trunc;
            end
         end
      end
   end

   // Single-entry output register with row/window end tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full    <= 1'b0;
         dout    <= '0;
         eop_out <= 1'b0;
         eol_out <= 1'b0;
      end else if (soft_rst) begin
         full    <= 1'b0;
         dout    <= '0;
         eop_out <= 1'b0;
         eol_out <= 1'b0;
      end else begin
         full <= win_acc | (full & ~out_val);
         if (win_acc) begin
            dout    <= din;
            eop_out <= x_last;
            eol_out <= x_last & y_last;
         end
      end
   end

endmodule

// File: tb/tb_eff_crop_win.sv
// Directed bench for eff_crop_win: drives small frames through the crop
// window and compares the emitted pixels, tags and frame measurements
// against values computed here.
module tb_eff_crop_win;

   logic        clk;
   logic        rst_n;
   logic        soft_rst;
   logic        op_start;
   logic [15:0] crop_x0;
   logic [15:0] crop_y0;
   logic [15:0] crop_w;
   logic [15:0] crop_h;
   logic        req_out;
   logic        rdy_in;
   logic        heff_in;
   logic        veff_in;
   logic [7:0]  din;
   logic        rdy_out;
   logic        req_in;
   logic [7:0]  dout;
   logic        eop_out;
   logic        eol_out;
   logic [15:0] frm_w;
   logic [15:0] frm_h;
   logic        frm_done;
   logic        err_trunc;

   int          nvec;
   int          nerr;
   int          n_done;
   int          n_err;
   int          rq_mode;
   logic        tog;
   logic        start_nxt;
   logic        srst_nxt;
   logic [9:0]  cap[$];
   logic [9:0]  expq[$];

   eff_crop_win #(.dat_w(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .soft_rst  (soft_rst),
      .op_start  (op_start),
      .crop_x0   (crop_x0),
      .crop_y0   (crop_y0),
      .crop_w    (crop_w),
      .crop_h    (crop_h),
      .req_out   (req_out),
      .rdy_in    (rdy_in),
      .heff_in   (heff_in),
      .veff_in   (veff_in),
      .din       (din),
      .rdy_out   (rdy_out),
      .req_in    (req_in),
      .dout      (dout),
      .eop_out   (eop_out),
      .eol_out   (eol_out),
      .frm_w     (frm_w),
      .frm_h     (frm_h),
      .frm_done  (frm_done),
      .err_trunc (err_trunc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, observe 1 ns later (the values
   // that the next rising edge will act on).
   task automatic tick(input logic h, input logic v, input logic [7:0] d, output logic took);
      @(negedge clk);
      heff_in  = h;
      veff_in  = v;
      din      = d;
      rdy_in   = 1'b1;
      op_start = start_nxt;
      start_nxt = 1'b0;
      soft_rst = srst_nxt;
      srst_nxt = 1'b0;
      case (rq_mode)
         0:       req_in = 1'b1;
         1:       begin req_in = tog; tog = ~tog; end
         default: req_in = 1'b0;
      endcase
      #1;
      if (rdy_out && req_in) cap.push_back({dout, eop_out, eol_out});
      if (frm_done) n_done++;
      if (err_trunc) n_err++;
      if (rq_mode == 1 && rdy_out && !req_in) chk("bp_req_out", {31'd0, req_out}, 32'd0);
      took = req_out & h & v;
   endtask

   task automatic send_pix(input int x, input int y);
      logic took;
      int   n;
      took = 1'b0;
      n = 0;
      while (!took && n < 40) begin
         tick(1'b1, 1'b1, 8'(y * 16 + x), took);
         n++;
      end
      if (!took) begin
         nvec++;
         nerr++;
         $error("FAIL accept_timeout: pixel x=%0d y=%0d not accepted, expected acceptance", x, y);
      end
   endtask

   // Frame of W x H; the last line runs straight into vertical blank so its
   // hfall coincides with vfall. op_start pulses at the first pixel of
   // start_line (negative: never).
   task automatic send_frame(input int W, input int H, input int start_line);
      logic t;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (y == start_line && x == 0) start_nxt = 1'b1;
            send_pix(x, y);
         end
         if (y != H - 1) repeat (2) tick(1'b0, 1'b1, 8'd0, t);
      end
      repeat (6) tick(1'b0, 1'b0, 8'd0, t);
   endtask

   // Expected window contents of a W x H frame
   task automatic add_win(input int x0, input int y0, input int w, input int h,
                          input int W, input int H);
      logic ep;
      logic el;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (x >= x0 && x < x0 + w && y >= y0 && y < y0 + h) begin
               ep = (x == x0 + w - 1);
               el = ep && (y == y0 + h - 1);
               expq.push_back({8'(y * 16 + x), ep, el});
            end
         end
      end
   endtask

   task automatic cmp_q(input string tag);
      chk({tag, "_count"}, cap.size(), expq.size());
      for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
         chk($sformatf("%s_px%0d", tag, i), {22'd0, cap[i]}, {22'd0, expq[i]});
      end
      cap.delete();
      expq.delete();
   endtask

   task automatic arm(input int x0, input int y0, input int w, input int h);
      logic t;
      crop_x0 = 16'(x0);
      crop_y0 = 16'(y0);
      crop_w  = 16'(w);
      crop_h  = 16'(h);
      start_nxt = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 8'd0, t);
   endtask

   initial begin
      logic t;
      nvec = 0; nerr = 0; n_done = 0; n_err = 0;
      rq_mode = 0; tog = 1'b1; start_nxt = 1'b0; srst_nxt = 1'b0;
      rst_n = 1'b0; soft_rst = 1'b0; op_start = 1'b0;
      crop_x0 = '0; crop_y0 = '0; crop_w = '0; crop_h = '0;
      rdy_in = 1'b0; heff_in = 1'b0; veff_in = 1'b0; din = '0; req_in = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_out", {31'd0, req_out}, 32'd0);
      chk("rst_rdy_out", {31'd0, rdy_out}, 32'd0);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      chk("rst_flags", {29'd0, eop_out, eol_out, err_trunc}, 32'd0);
      chk("rst_frm_w", {16'd0, frm_w}, 32'd0);
      chk("rst_frm_h", {16'd0, frm_h}, 32'd0);
      chk("rst_frm_done", {31'd0, frm_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle block ignores the upstream
      tick(1'b1, 1'b1, 8'hAA, t);
      chk("idle_req_out", {31'd0, req_out}, 32'd0);

      // 8x4 frame, window (2,1) 3x2, downstream always ready
      arm(2, 1, 3, 2);
      send_frame(8, 4, -1);
      add_win(2, 1, 3, 2, 8, 4);
      cmp_q("win_basic");
      chk("basic_frm_w", {16'd0, frm_w}, 32'd8);
      chk("basic_frm_h", {16'd0, frm_h}, 32'd4);
      chk("basic_done", n_done, 1);
      chk("basic_trunc", n_err, 0);
      n_done = 0; n_err = 0;

      // Same frame, downstream toggling ready
      rq_mode = 1;
      send_frame(8, 4, -1);
      add_win(2, 1, 3, 2, 8, 4);
      cmp_q("win_toggle");
      chk("toggle_done", n_done, 1);
      chk("toggle_trunc", n_err, 0);
      n_done = 0; n_err = 0;
      rq_mode = 0;

      // Window hanging off the right edge: x=6,7 only, no eop
      arm(6, 1, 4, 1);
      send_frame(8, 4, -1);
      add_win(6, 1, 4, 1, 8, 4);
      cmp_q("win_right");
      n_done = 0; n_err = 0;

      // Window taller than the frame: truncation flagged
      arm(0, 0, 2, 5);
      send_frame(8, 4, -1);
      add_win(0, 0, 2, 5, 8, 4);
      cmp_q("win_tall");
      chk("tall_frm_h", {16'd0, frm_h}, 32'd4);
      chk("tall_done", n_done, 1);
      chk("tall_trunc", n_err, 1);
      n_done = 0; n_err = 0;

      // op_start mid-frame: new crop values only take hold from the next
      // frame; line 0 still uses the old shadow window
      crop_x0 = 16'd2; crop_y0 = 16'd1; crop_w = 16'd3; crop_h = 16'd2;
      send_frame(8, 4, 1);
      add_win(0, 0, 2, 5, 8, 1);
      cmp_q("midstart_a");
      chk("midstart_a_done", n_done, 0);
      send_frame(8, 4, -1);
      add_win(2, 1, 3, 2, 8, 4);
      cmp_q("midstart_b");
      chk("midstart_b_done", n_done, 1);
      chk("midstart_b_trunc", n_err, 0);
      n_done = 0; n_err = 0;

      // soft_rst while a pixel is held and downstream is stalled
      rq_mode = 2;
      for (int x = 0; x < 8; x++) send_pix(x, 0);
      repeat (2) tick(1'b0, 1'b1, 8'd0, t);
      for (int x = 0; x < 3; x++) send_pix(x, 1);
      tick(1'b1, 1'b1, 8'h13, t);
      chk("held_rdy_out", {31'd0, rdy_out}, 32'd1);
      chk("held_req_out", {31'd0, req_out}, 32'd0);
      chk("held_dout", {24'd0, dout}, 32'h12);
      srst_nxt = 1'b1;
      tick(1'b1, 1'b1, 8'h13, t);
      rq_mode = 0;
      tick(1'b1, 1'b1, 8'h13, t);
      chk("srst_rdy_out", {31'd0, rdy_out}, 32'd0);
      chk("srst_req_out", {31'd0, req_out}, 32'd0);
      chk("srst_frm_w", {16'd0, frm_w}, 32'd0);
      chk("srst_frm_h", {16'd0, frm_h}, 32'd0);
      repeat (3) tick(1'b1, 1'b1, 8'h14, t);
      chk("srst_idle_req_out", {31'd0, req_out}, 32'd0);
      chk("srst_no_output", cap.size(), 0);
      start_nxt = 1'b1;
      tick(1'b0, 1'b0, 8'd0, t);
      tick(1'b0, 1'b0, 8'd0, t);
      chk("rearm_req_out", {31'd0, req_out}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
